tage_table_arbiter: RTL
=======================

# tage_table_arbiter

Arbitrates the single port of one TAGE tagged-table BRAM between prediction lookups (reads) and predictor updates (writes). Updates are posted into a small in-order queue so the update stage never stalls the lookup stage. A starvation counter bounds how long queued writes can wait behind back-to-back lookups. The block sits between the index/tag stage, the update stage and the table BRAM; it is sequenced by the buffer controller's `index_tag_enable`, `table_read_en` and `update_enable` phases.

## Interface
- `ADDR_W`, 10, table index width.
- `DATA_W`, 16, entry width: tag + prediction counter + useful bits.
- `QDEPTH`, 4, update queue depth (power of two, ≥2).
- `STARVE_MAX`, 8, number of cycles a non-empty queue waits before a write is forced.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `lookup_req` in 1: lookup request, held until granted.
- `lookup_addr` in ADDR_W: lookup index.
- `lookup_grant` out 1: lookup is issued this cycle (combinational).
- `lookup_data_valid` out 1: `lookup_data` is valid (registered).
- `lookup_data` out DATA_W: entry read for the granted lookup.
- `upd_req` in 1: update write request.
- `upd_addr` in ADDR_W: update index.
- `upd_data` in DATA_W: new entry value.
- `upd_ready` out 1: queue can accept an update (`count < QDEPTH`).
- `table_en` out 1: BRAM enable.
- `table_we` out 1: BRAM write enable.
- `table_addr` out ADDR_W: BRAM address.
- `table_wdata` out DATA_W: BRAM write data.
- `table_rdata` in DATA_W: BRAM read data, 1-cycle synchronous read.
- `queue_count` out $clog2(QDEPTH+1): number of occupied queue entries.

## Operation
- Update queue: circular FIFO (write pointer, read pointer, count).
  - An update is enqueued at the clock edge when `upd_req && upd_ready`.
  - `upd_ready` is derived from the registered count only. When the queue is full, no enqueue occurs, even if a dequeue happens in the same cycle.
  - Simultaneous enqueue and dequeue leaves the count unchanged.
- Per-cycle arbitration, first match wins:
  1. Queue non-empty and `starve_cnt == STARVE_MAX`: WRITE.
  2. `lookup_req`: READ.
  3. Queue non-empty: WRITE.
  4. Otherwise: IDLE.
- READ: `table_en=1`, `table_we=0`, `table_addr=lookup_addr`, `lookup_grant=1`.
- WRITE: `table_en=1`, `table_we=1`, address and data taken from the queue head, head dequeued at the edge.
- IDLE: `table_en=0`, `table_we=0`, `table_addr=0`, `table_wdata=0`.
- `starve_cnt` (saturating at STARVE_MAX):
  - Cleared when the queue is empty or a WRITE issues.
  - Otherwise incremented each cycle.
- A lookup that is not granted must be held by the requester. The arbiter does not latch it.
- While `reset` is low:
  - All combinational outputs are forced to 0: `lookup_grant`, `table_en`, `table_we`, `upd_ready`.
  - The queue is emptied, `starve_cnt`=0, `lookup_data_valid`=0, `lookup_data`=0.
  - Asserting reset mid-operation discards all queued updates and any in-flight lookup.

## Timing
- Grant to data: `lookup_data_valid` rises exactly 1 cycle after `lookup_grant`, for 1 cycle. `lookup_data` holds its last value otherwise.
- Throughput: one table operation per cycle.
- Write latency from enqueue: at least 1 cycle. Worst case with continuous lookups is STARVE_MAX+1 cycles for the head entry.
- Reset values: `lookup_data_valid`=0, `lookup_data`=0, `queue_count`=0. All combinational outputs are 0 while in reset.
- An update enqueued in the same cycle as a lookup to the same address is not visible to that lookup.

## Configuration
- `TAGE_ARB_FWD_EN` defined: read-after-write forwarding.
  - In the grant cycle, `lookup_addr` is compared against every valid queue entry.
  - The youngest match's data and a hit flag are registered.
  - Next cycle, `lookup_data` = forwarded data on hit, else `table_rdata`.
  - The entry being dequeued in the grant cycle does not participate, because the arbiter issues only one operation per cycle.
- `TAGE_ARB_FWD_EN` undefined: `lookup_data` = `table_rdata` always. A lookup may return stale data for an address with a pending update. No comparators are built.

## Test plan
- Reset, then idle with all inputs 0 -> `table_en`=0, `upd_ready`=1, `queue_count`=0, `lookup_data_valid`=0.
- Lookup only: `lookup_req=1`, addr 0x05, BRAM returns 0xABCD -> grant in the same cycle, `table_addr`=0x05, and next cycle `lookup_data_valid`=1, `lookup_data`=0xABCD.
- Starvation: 4 updates queued, then `lookup_req` held high for 20 cycles -> first forced write at STARVE_MAX=8, one write per 9 cycles, `lookup_grant` low exactly in the write cycles.
- Full queue: 6 back-to-back `upd_req` with `lookup_req` held high -> `upd_ready` falls after 4 accepts, `queue_count`=4, and the 5th/6th are not enqueued until a write drains.
- Forwarding with `TAGE_ARB_FWD_EN`: enqueue addr 0x10 = 0x1111, then addr 0x10 = 0x2222, then lookup 0x10 while BRAM holds 0x0000 -> `lookup_data`=0x2222. Without the macro -> `lookup_data`=0x0000.
- Reset mid-operation: 3 updates queued, pull `reset` low for 1 cycle -> `queue_count`=0, no BRAM write occurs afterwards, `lookup_data_valid`=0.

Source files
------------

// File: rtl/tage_table_arbiter.sv
// tage_table_arbiter: shares one TAGE tagged-table BRAM port between lookups and posted updates
// Ports:
//   clk, reset (async, active-low)
//   lookup_req/lookup_addr -> lookup_grant (comb), lookup_data_valid/lookup_data (one cycle after grant)
//   upd_req/upd_addr/upd_data -> upd_ready; updates are posted into an in-order queue
//   table_en/table_we/table_addr/table_wdata -> BRAM, table_rdata <- BRAM (1-cycle synchronous read)
//   queue_count: occupied update-queue entries
// Optional: define TAGE_ARB_FWD_EN to forward the youngest queued update to a lookup of the same index.
module tage_table_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         lookup_req,
    input  logic [ADDR_W-1:0]            lookup_addr,
    output logic                         lookup_grant,
    output logic                         lookup_data_valid,
    output logic [DATA_W-1:0]            lookup_data,
    input  logic                         upd_req,
    input  logic [ADDR_W-1:0]            upd_addr,
    input  logic [DATA_W-1:0]            upd_data,
    output logic                         upd_ready,
    output logic                         table_en,
    output logic                         table_we,
    output logic [ADDR_W-1:0]            table_addr,
    output logic [DATA_W-1:0]            table_wdata,
    input  logic [DATA_W-1:0]            table_rdata,
    output logic [$clog2(QDEPTH+1)-1:0]  queue_count
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0] q_addr [QDEPTH];
    logic [DATA_W-1:0] q_data [QDEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starve_cnt;
    logic [DATA_W-1:0] last_data, rd_data;
    logic              not_empty, force_wr, do_read, do_write, enq;

    // Every combinational output is qualified with reset so the BRAM sees nothing while in reset.
    assign not_empty    = count != '0;
    assign force_wr     = not_empty && starve_cnt == SW'(STARVE_MAX);
    assign do_write     = reset && not_empty && (force_wr || !lookup_req);
    assign do_read      = reset && lookup_req && !force_wr;
    assign upd_ready    = reset && count < CW'(QDEPTH);
    assign enq          = upd_req && upd_ready;
    assign lookup_grant = do_read;
    assign table_en     = do_read || do_write;
    assign table_we     = do_write;
    assign table_addr   = do_write ? q_addr[rd_ptr] : do_read ? lookup_addr : '0;
    assign table_wdata  = do_write ? q_data[rd_ptr] : '0;
    assign queue_count  = count;
    // Data is only fresh in the valid cycle; afterwards the last delivered value is held.
    assign lookup_data  = lookup_data_valid ? rd_data : last_data;

    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[wr_ptr] <= upd_addr;
            q_data[wr_ptr] <= upd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            starve_cnt        <= '0;
            lookup_data_valid <= 1'b0;
            last_data         <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_write) rd_ptr <= rd_ptr + 1'b1;
            count             <= count + CW'(enq) - CW'(do_write);
            starve_cnt        <= (!not_empty || do_write) ? '0 :
                                 (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
            lookup_data_valid <= do_read;
            if (lookup_data_valid) last_data <= rd_data;
        end
    end

`ifdef TAGE_ARB_FWD_EN
    logic              fwd_hit_n, fwd_hit;
    logic [DATA_W-1:0] fwd_data_n, fwd_data;

    // Walk from oldest to youngest so the last match wins. A read never coincides with a
    // dequeue, so every occupied entry is still pending in the grant cycle.
    always_comb begin
        fwd_hit_n  = 1'b0;
        fwd_data_n = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (CW'(i) < count && q_addr[rd_ptr + PW'(i)] == lookup_addr) begin
                fwd_hit_n  = 1'b1;
                fwd_data_n = q_data[rd_ptr + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else if (do_read) begin
            fwd_hit  <= fwd_hit_n;
            fwd_data <= fwd_data_n;
        end
    end

    assign rd_data = fwd_hit ? fwd_data : table_rdata;
`else
    assign rd_data = table_rdata;
`endif
endmodule
